raster_multi: RTL and testbench

- Parametrised scan-line rasteriser; successor to the fixed two-triangle rasteriser.
- Takes the VGA beam position and per-frame/per-line coefficients from the vertex stage, and tests NTRI triangles per sample with incremental edge functions.
- Resolves overlap by fixed index priority, with optional back-face culling, and steps barycentrics for texture addressing via an external texture ROM.
- Emits 6-bit RGB to top.

---
 rtl/raster_multi.sv | 204 ++++++++++++++++++++
 tb/tb_raster_multi.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_multi.sv
// Scan-line rasteriser: NTRI triangles tested per sample with incremental edge
// functions, fixed index priority, optional back-face culling and texture lookup.
module raster_multi #(
    parameter int          NTRI     = 2,
    parameter int          EW       = 20,
    parameter int          BW       = 22,
    parameter int          FRAC     = 20,
    parameter int          TEXB     = 7,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          H_TOTAL  = 800,
    parameter int          V_TOTAL  = 525,
    parameter logic [5:0]  BG_COLOR = 6'b010101,
    localparam int         IW       = (NTRI > 1) ? $clog2(NTRI) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic [NTRI*3*EW-1:0]   e_init,
    input  logic [NTRI*3*EW-1:0]   e_dx,
    input  logic [NTRI*2*BW-1:0]   b_init,
    input  logic [NTRI*2*BW-1:0]   b_dx,
    input  logic [NTRI*6-1:0]      front_color,
    input  logic [NTRI*6-1:0]      back_color,
    input  logic [NTRI-1:0]        tex_en,
    input  logic [NTRI-1:0]        uv_swap,
    input  logic                   cull_back,
    output logic [TEXB-1:0]        tex_u,
    output logic [TEXB-1:0]        tex_v,
    input  logic                   texel,
    output logic                   hit_valid,
    output logic [IW-1:0]          hit_idx,
    output logic [5:0]             rgb
);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);

    typedef enum logic {PH_SAMPLE, PH_SHADE} phase_t;

    phase_t          phase_q, phase_d;
    logic            armed_q, armed_d;
    logic [EW-1:0]   e_q [NTRI][3];
    logic [EW-1:0]   e_d [NTRI][3];
    logic [BW-1:0]   b_q [NTRI][2];
    logic [BW-1:0]   b_d [NTRI][2];
    logic [BW-1:0]   u_q [NTRI];
    logic [BW-1:0]   u_d [NTRI];
    logic [BW-1:0]   v_q [NTRI];
    logic [BW-1:0]   v_d [NTRI];
    logic            bg_q, bg_d;
    logic            back_q, back_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   hit_idx_q, hit_idx_d;
    logic            hit_valid_q, hit_valid_d;
    logic [5:0]      rgb_q, rgb_d;

    logic            reload, active;
    logic [5:0]      fc [NTRI];
    logic [5:0]      bc [NTRI];
    logic [BW-1:0]   iy_n, iz_n;
    logic            found, is_front, is_back;
    logic [2:0]      neg, pos;
    logic            unused_uv;

    assign reload = ((x == X_LAST) && (y < Y_ACT)) || (y == Y_LAST);
    assign active = (x < X_ACT) && (y < Y_ACT);

    always_comb begin
        for (int unsigned k = 0; k < NTRI; k++) begin
            fc[k] = front_color[6*k +: 6];
            bc[k] = back_color[6*k +: 6];
        end
    end

    // Only the texture-address window of u/v reaches an output.
    always_comb begin
        unused_uv = 1'b0;
        for (int unsigned k = 0; k < NTRI; k++) begin
            unused_uv = unused_uv ^ (^u_q[k]) ^ (^v_q[k]);
        end
    end

    always_comb begin
        phase_d     = phase_q;
        armed_d     = armed_q;
        e_d         = e_q;
        b_d         = b_q;
        u_d         = u_q;
        v_d         = v_q;
        bg_d        = bg_q;
        back_d      = back_q;
        idx_d       = idx_q;
        rgb_d       = rgb_q;
        hit_valid_d = hit_valid_q;
        hit_idx_d   = hit_idx_q;
        iy_n        = '0;
        iz_n        = '0;
        found       = 1'b0;
        is_front    = 1'b0;
        is_back     = 1'b0;
        neg         = '0;
        pos         = '0;

        if (reload) begin
            for (int unsigned k = 0; k < NTRI; k++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    e_d[k][j] = e_init[(3*k+j)*EW +: EW];
                end
                b_d[k][0] = b_init[(2*k)*BW +: BW];
                b_d[k][1] = b_init[(2*k+1)*BW +: BW];
            end
            phase_d = PH_SAMPLE;
            armed_d = 1'b1;
        end else if (active && armed_q) begin
            if (phase_q == PH_SAMPLE) begin
                phase_d = PH_SHADE;
                for (int unsigned k = 0; k < NTRI; k++) begin
                    iy_n      = b_q[k][0] + b_dx[(2*k)*BW +: BW];
                    iz_n      = b_q[k][1] + b_dx[(2*k+1)*BW +: BW];
                    b_d[k][0] = iy_n;
                    b_d[k][1] = iz_n;
                    u_d[k]    = uv_swap[k] ? (iy_n + iz_n) : iz_n;
                    v_d[k]    = uv_swap[k] ? iy_n : (iy_n + iz_n);
                end
                // Lowest index wins; a culled back face lets the search continue.
                bg_d   = 1'b1;
                back_d = 1'b0;
                idx_d  = '0;
                for (int unsigned k = 0; k < NTRI; k++) begin
                    for (int unsigned j = 0; j < 3; j++) begin
                        neg[j] = e_q[k][j][EW-1];
                        pos[j] = !e_q[k][j][EW-1] && (e_q[k][j] != '0);
                    end
                    is_front = &neg;
                    is_back  = &pos;
                    if (!found && (is_front || (is_back && !cull_back))) begin
                        found  = 1'b1;
                        bg_d   = 1'b0;
                        back_d = !is_front;
                        idx_d  = IW'(k);
                    end
                end
            end else begin
                phase_d = PH_SAMPLE;
                if (bg_q)
                    rgb_d = BG_COLOR;
                else if (back_q)
                    rgb_d = bc[idx_q];
                else if (tex_en[idx_q])
                    rgb_d = texel ? fc[idx_q] : 6'b0;
                else
                    rgb_d = fc[idx_q];
                hit_valid_d = !bg_q;
                hit_idx_d   = idx_q;
                for (int unsigned k = 0; k < NTRI; k++) begin
                    for (int unsigned j = 0; j < 3; j++) begin
                        e_d[k][j] = e_q[k][j] + e_dx[(3*k+j)*EW +: EW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_SAMPLE;
            armed_q     <= 1'b0;
            e_q         <= '{default: '0};
            b_q         <= '{default: '0};
            u_q         <= '{default: '0};
            v_q         <= '{default: '0};
            bg_q        <= 1'b0;
            back_q      <= 1'b0;
            idx_q       <= '0;
            rgb_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            armed_q     <= armed_d;
            e_q         <= e_d;
            b_q         <= b_d;
            u_q         <= u_d;
            v_q         <= v_d;
            bg_q        <= bg_d;
            back_q      <= back_d;
            idx_q       <= idx_d;
            rgb_q       <= rgb_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    assign tex_u     = u_q[idx_q][FRAC-1 -: TEXB];
    assign tex_v     = v_q[idx_q][FRAC-1 -: TEXB];
    assign rgb       = rgb_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_raster_multi.sv
// Bench for raster_multi: drives a VGA-style beam and checks each sample against
// a closed-form per-sample model of edge functions, priority and shading.
module tb_raster_multi;

    localparam int         NTRI = 2;
    localparam int         EW   = 20;
    localparam int         BW   = 22;
    localparam int         FRAC = 20;
    localparam int         TEXB = 7;
    localparam logic [5:0] BG   = 6'b010101;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [9:0]           x, y;
    logic [NTRI*3*EW-1:0] e_init, e_dx;
    logic [NTRI*2*BW-1:0] b_init, b_dx;
    logic [NTRI*6-1:0]    front_color, back_color;
    logic [NTRI-1:0]      tex_en, uv_swap;
    logic                 cull_back;
    logic [TEXB-1:0]      tex_u, tex_v;
    logic                 texel;
    logic                 hit_valid;
    logic [0:0]           hit_idx;
    logic [5:0]           rgb;

    int tests = 0;
    int fails = 0;

    logic [5:0]      obs_rgb [320];
    logic            obs_hv  [320];
    logic [0:0]      obs_idx [320];
    logic [TEXB-1:0] obs_tu  [320];
    logic [5:0]      obs_hold;

    raster_multi #(.NTRI(NTRI), .EW(EW), .BW(BW), .FRAC(FRAC), .TEXB(TEXB),
                   .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .e_init(e_init), .e_dx(e_dx), .b_init(b_init), .b_dx(b_dx),
        .front_color(front_color), .back_color(back_color),
        .tex_en(tex_en), .uv_swap(uv_swap), .cull_back(cull_back),
        .tex_u(tex_u), .tex_v(tex_v), .texel(texel),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Texture ROM stub: texel is the LSB of the column address.
    assign texel = tex_u[0];

    task automatic step(input int xv, input int yv);
        x = 10'(xv);
        y = 10'(yv);
        @(posedge clk);
        #1;
    endtask

    task automatic prime();
        step(799, 524);
    endtask

    task automatic run_line(input int yv);
        for (int xi = 0; xi < 800; xi++) begin
            step(xi, yv);
            if (xi < 640 && xi % 2 == 0) obs_tu[xi/2] = tex_u;
            if (xi < 640 && xi % 2 == 1) begin
                obs_rgb[xi/2] = rgb;
                obs_hv[xi/2]  = hit_valid;
                obs_idx[xi/2] = hit_idx;
            end
            if (xi == 700) obs_hold = rgb;
        end
    endtask

    task automatic clear_cfg();
        e_init = '0; e_dx = '0; b_init = '0; b_dx = '0;
        front_color = '0; back_color = '0;
        tex_en = '0; uv_swap = '0; cull_back = 1'b0;
    endtask

    task automatic set_tri(input int k, input int e0, input int e1, input int e2,
                           input int d0, input int d1, input int d2,
                           input logic [5:0] fcv, input logic [5:0] bcv,
                           input logic ten, input logic swp);
        e_init[(3*k+0)*EW +: EW] = EW'(e0);
        e_init[(3*k+1)*EW +: EW] = EW'(e1);
        e_init[(3*k+2)*EW +: EW] = EW'(e2);
        e_dx[(3*k+0)*EW +: EW]   = EW'(d0);
        e_dx[(3*k+1)*EW +: EW]   = EW'(d1);
        e_dx[(3*k+2)*EW +: EW]   = EW'(d2);
        front_color[6*k +: 6]    = fcv;
        back_color[6*k +: 6]     = bcv;
        tex_en[k]                = ten;
        uv_swap[k]               = swp;
    endtask

    task automatic random_cfg();
        clear_cfg();
        for (int k = 0; k < NTRI; k++) begin
            set_tri(k, int'($urandom_range(800)) - 400, int'($urandom_range(800)) - 400,
                    int'($urandom_range(800)) - 400, int'($urandom_range(10)) - 5,
                    int'($urandom_range(10)) - 5, int'($urandom_range(10)) - 5,
                    6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            b_init[(2*k)*BW +: BW]   = BW'($urandom);
            b_init[(2*k+1)*BW +: BW] = BW'($urandom);
            b_dx[(2*k)*BW +: BW]     = BW'($urandom);
            b_dx[(2*k+1)*BW +: BW]   = BW'($urandom);
        end
        cull_back = 1'($urandom);
    endtask

    // Sample s of a line: edges = init + s*dx, barycentrics = init + (s+1)*dx.
    function automatic void m_pixel(input int s, output logic [5:0] ergb,
                                    output logic ehv, output int eidx,
                                    output logic [TEXB-1:0] etu);
        int         win;
        int         k0;
        logic       bf;
        longint     t;
        logic [BW-1:0] iy, iz, u;
        win = -1;
        bf  = 1'b0;
        for (int k = 0; k < NTRI; k++) begin
            int nneg;
            int npos;
            nneg = 0;
            npos = 0;
            for (int j = 0; j < 3; j++) begin
                longint ev;
                logic [EW-1:0] w;
                ev = longint'($signed(e_init[(3*k+j)*EW +: EW]))
                   + longint'(s) * longint'($signed(e_dx[(3*k+j)*EW +: EW]));
                w = ev[EW-1:0];
                if ($signed(w) < 0) nneg++;
                else if ($signed(w) > 0) npos++;
            end
            if (win < 0 && (nneg == 3 || (npos == 3 && !cull_back))) begin
                win = k;
                bf  = (npos == 3);
            end
        end
        k0 = (win < 0) ? 0 : win;
        t  = longint'(b_init[(2*k0)*BW +: BW]) + longint'(s+1) * longint'(b_dx[(2*k0)*BW +: BW]);
        iy = t[BW-1:0];
        t  = longint'(b_init[(2*k0+1)*BW +: BW]) + longint'(s+1) * longint'(b_dx[(2*k0+1)*BW +: BW]);
        iz = t[BW-1:0];
        u  = uv_swap[k0] ? (iy + iz) : iz;
        etu = u[FRAC-1 -: TEXB];
        ehv  = (win >= 0);
        eidx = k0;
        if (win < 0)            ergb = BG;
        else if (bf)            ergb = back_color[6*win +: 6];
        else if (!tex_en[win])  ergb = front_color[6*win +: 6];
        else                    ergb = etu[0] ? front_color[6*win +: 6] : 6'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clear_cfg();
        step(0, 0);
        step(1, 0);
        tests++;
        if (rgb !== 6'b0 || hit_valid !== 1'b0 || hit_idx !== 1'b0) begin
            fails++;
            $display("FAIL reset_out got rgb=%b hv=%b idx=%b want 000000 0 0", rgb, hit_valid, hit_idx);
        end
        tests++;
        if (tex_u !== '0 || tex_v !== '0) begin
            fails++;
            $display("FAIL reset_tex got u=%0d v=%0d want 0 0", tex_u, tex_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_background();
        clear_cfg();
        prime();
        run_line(0);
        for (int s = 0; s < 320; s++) begin
            tests++;
            if (obs_rgb[s] !== BG || obs_hv[s] !== 1'b0) begin
                fails++;
                $display("FAIL background s=%0d got rgb=%b hv=%b want %b 0", s, obs_rgb[s], obs_hv[s], BG);
            end
        end
    endtask

    task automatic test_edge_step();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        clear_cfg();
        set_tri(0, -5, -5, -5, 1, 0, 0, 6'b001100, 6'b111111, 1'b0, 1'b0);
        prime();
        run_line(0);
        tests++;
        if (obs_rgb[3] !== 6'b001100 || obs_rgb[4] !== 6'b001100 || obs_rgb[5] !== BG) begin
            fails++;
            $display("FAIL edge_zero got s3=%b s4=%b s5=%b want 001100 001100 %b",
                     obs_rgb[3], obs_rgb[4], obs_rgb[5], BG);
        end
        for (int s = 0; s < 320; s++) begin
            m_pixel(s, er, eh, ei, et);
            tests++;
            if (obs_rgb[s] !== er || obs_hv[s] !== eh || (eh && obs_idx[s] !== 1'(ei))) begin
                fails++;
                $display("FAIL edge_step s=%0d got rgb=%b hv=%b idx=%0d want %b %b %0d",
                         s, obs_rgb[s], obs_hv[s], obs_idx[s], er, eh, ei);
            end
        end
    endtask

    task automatic test_priority_cull();
        for (int c = 0; c < 2; c++) begin
            clear_cfg();
            set_tri(0, 3, 3, 3, 0, 0, 0, 6'b001100, 6'b110000, 1'b0, 1'b0);
            set_tri(1, -3, -3, -3, 0, 0, 0, 6'b000011, 6'b101010, 1'b0, 1'b0);
            cull_back = 1'(c);
            prime();
            run_line(0);
            for (int s = 0; s < 320; s += 53) begin
                tests++;
                if (c == 0 && (obs_rgb[s] !== 6'b110000 || obs_idx[s] !== 1'b0 || obs_hv[s] !== 1'b1)) begin
                    fails++;
                    $display("FAIL prio_nocull s=%0d got rgb=%b idx=%0d hv=%b want 110000 0 1",
                             s, obs_rgb[s], obs_idx[s], obs_hv[s]);
                end
                if (c == 1 && (obs_rgb[s] !== 6'b000011 || obs_idx[s] !== 1'b1 || obs_hv[s] !== 1'b1)) begin
                    fails++;
                    $display("FAIL prio_cull s=%0d got rgb=%b idx=%0d hv=%b want 000011 1 1",
                             s, obs_rgb[s], obs_idx[s], obs_hv[s]);
                end
            end
        end
    endtask

    task automatic test_texture();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        clear_cfg();
        set_tri(0, -1, -1, -1, 0, 0, 0, 6'b101101, 6'b110000, 1'b1, 1'b0);
        b_dx[(2*0+1)*BW +: BW] = BW'(1 << 13);
        prime();
        run_line(0);
        for (int s = 0; s < 320; s++) begin
            m_pixel(s, er, eh, ei, et);
            tests++;
            if (obs_tu[s] !== 7'(s + 1) || obs_rgb[s] !== er) begin
                fails++;
                $display("FAIL texture s=%0d got u=%0d rgb=%b want %0d %b",
                         s, obs_tu[s], obs_rgb[s], 7'(s + 1), er);
            end
        end
    endtask

    task automatic test_wrap();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        int d;
        d = (1 << 19) - 1;
        clear_cfg();
        set_tri(0, -1, -1, -1, d, d, d, 6'b001100, 6'b110000, 1'b0, 1'b0);
        prime();
        run_line(0);
        tests++;
        if (obs_rgb[0] !== 6'b001100 || obs_rgb[1] !== 6'b110000 || obs_rgb[2] !== 6'b001100) begin
            fails++;
            $display("FAIL wrap_sign got s0=%b s1=%b s2=%b want 001100 110000 001100",
                     obs_rgb[0], obs_rgb[1], obs_rgb[2]);
        end
        for (int s = 0; s < 320; s++) begin
            m_pixel(s, er, eh, ei, et);
            tests++;
            if (obs_rgb[s] !== er || obs_hv[s] !== eh) begin
                fails++;
                $display("FAIL wrap s=%0d got rgb=%b hv=%b want %b %b", s, obs_rgb[s], obs_hv[s], er, eh);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        for (int f = 0; f < 5; f++) begin
            random_cfg();
            prime();
            run_line(0);
            for (int s = 0; s < 320; s++) begin
                m_pixel(s, er, eh, ei, et);
                tests++;
                if (obs_rgb[s] !== er || obs_hv[s] !== eh || (eh && obs_idx[s] !== 1'(ei))) begin
                    fails++;
                    $display("FAIL random f=%0d s=%0d got rgb=%b hv=%b idx=%0d want %b %b %0d",
                             f, s, obs_rgb[s], obs_hv[s], obs_idx[s], er, eh, ei);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        random_cfg();
        prime();
        for (int ln = 0; ln < 2; ln++) begin
            run_line(ln);
            for (int s = 0; s < 320; s++) begin
                m_pixel(s, er, eh, ei, et);
                tests++;
                if (obs_rgb[s] !== er || obs_hv[s] !== eh || (eh && obs_idx[s] !== 1'(ei))) begin
                    fails++;
                    $display("FAIL b2b line=%0d s=%0d got rgb=%b hv=%b idx=%0d want %b %b %0d",
                             ln, s, obs_rgb[s], obs_hv[s], obs_idx[s], er, eh, ei);
                end
            end
            m_pixel(319, er, eh, ei, et);
            tests++;
            if (obs_hold !== er) begin
                fails++;
                $display("FAIL hblank_hold line=%0d got %b want %b", ln, obs_hold, er);
            end
        end
        for (int xi = 0; xi < 100; xi++) begin
            step(xi, 480);
            tests++;
            if (rgb !== er || hit_valid !== eh) begin
                fails++;
                $display("FAIL vblank_hold x=%0d got rgb=%b hv=%b want %b %b", xi, rgb, hit_valid, er, eh);
            end
        end
    endtask

    task automatic test_midline_reset();
        logic [5:0] er; logic eh; int ei; logic [TEXB-1:0] et;
        clear_cfg();
        set_tri(0, -5, -5, -5, 1, 0, 0, 6'b001100, 6'b111111, 1'b0, 1'b0);
        set_tri(1, -400, -400, -400, 3, 2, 1, 6'b100001, 6'b011110, 1'b0, 1'b0);
        prime();
        for (int xi = 0; xi < 300; xi++) step(xi, 0);
        reset = 1'b1;
        step(300, 0);
        reset = 1'b0;
        for (int xi = 301; xi < 799; xi++) begin
            step(xi, 0);
            tests++;
            if (rgb !== 6'b0 || hit_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_hold x=%0d got rgb=%b hv=%b want 000000 0", xi, rgb, hit_valid);
            end
        end
        step(799, 0);
        run_line(1);
        for (int s = 0; s < 320; s++) begin
            m_pixel(s, er, eh, ei, et);
            tests++;
            if (obs_rgb[s] !== er || obs_hv[s] !== eh || (eh && obs_idx[s] !== 1'(ei))) begin
                fails++;
                $display("FAIL midreset_resume s=%0d got rgb=%b hv=%b idx=%0d want %b %b %0d",
                         s, obs_rgb[s], obs_hv[s], obs_idx[s], er, eh, ei);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        x = '0;
        y = '0;
        clear_cfg();
        test_reset();
        test_background();
        test_edge_step();
        test_priority_cull();
        test_texture();
        test_wrap();
        test_random();
        test_back_to_back();
        test_midline_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
